// File: rtl/line_buffer_pkg.sv
// Shared constants for the line buffer, conv window and MAC blocks.
package line_buffer_pkg;

  localparam int LB_DATA_W       = 17;
  localparam int LB_IMAGE_WIDTH  = 28;
  localparam int LB_IMAGE_HEIGHT = 28;
  localparam int LB_KERNEL_WIDTH = 5;

  // Tap 0 is the live pixel; taps from TAP_FIRST_LINE up come out of storage.
  localparam int TAP_CUR        = 0;
  localparam int TAP_FIRST_LINE = 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/line_buffer_if.sv
// Pixel-in / column-out bundle between the pixel source, line buffer and conv window.
interface line_buffer_if
  import line_buffer_pkg::*;
#(
  parameter int DATA_W       = LB_DATA_W,
  parameter int IMAGE_WIDTH  = LB_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = LB_IMAGE_HEIGHT,
  parameter int KERNEL_WIDTH = LB_KERNEL_WIDTH
);
  localparam int COL_W = clog2(IMAGE_WIDTH);
  localparam int ROW_W = clog2(IMAGE_HEIGHT);

  logic                           clear;
  logic                           in_valid;
  logic signed [DATA_W-1:0]       in_data;
  logic                           out_valid;
  logic                           out_win_valid;
  logic [KERNEL_WIDTH*DATA_W-1:0] out_taps;
  logic [COL_W-1:0]               out_col;
  logic [ROW_W-1:0]               out_row;
  logic                           frame_done;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_win_valid, out_taps, out_col, out_row, frame_done
  );

  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_win_valid, out_taps, out_col, out_row, frame_done
  );

endinterface

// File: rtl/line_buffer_line.sv
// One circular image line: combinational read and write at the same external pointer.
module line_buffer_line
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W,
  parameter int DEPTH  = LB_IMAGE_WIDTH,
  parameter int PTR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read returns the pre-write value; the caller samples it on the same edge.
  assign rdata_o = mem_q[ptr_i];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[ptr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_buffer.sv
// KERNEL_WIDTH-1 line delay producing one vertical tap column per accepted pixel.
// Optional runtime line width under LINE_BUFFER_CFG_WIDTH_EN.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int DATA_W       = LB_DATA_W,
  parameter int IMAGE_WIDTH  = LB_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = LB_IMAGE_HEIGHT,
  parameter int KERNEL_WIDTH = LB_KERNEL_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
`ifdef LINE_BUFFER_CFG_WIDTH_EN
  input  logic [clog2(IMAGE_WIDTH+1)-1:0]   cfg_width,
`endif
  line_buffer_if.slave                      bus
);

  localparam int COL_W  = clog2(IMAGE_WIDTH);
  localparam int ROW_W  = clog2(IMAGE_HEIGHT);
  localparam int NLINES = KERNEL_WIDTH - 1;

  logic accept;
  logic last_col, last_row;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic             vld_q, vld_d;
  logic             win_q, win_d;
  logic             fd_q, fd_d;

  logic [KERNEL_WIDTH-1:0][DATA_W-1:0] taps_q, taps_d;
  logic [NLINES-1:0][DATA_W-1:0]       rd, wd;

  assign accept   = bus.in_valid & ~bus.clear;
  assign last_row = (row_q == ROW_W'(IMAGE_HEIGHT - 1));

`ifdef LINE_BUFFER_CFG_WIDTH_EN
  localparam int WID_W = clog2(IMAGE_WIDTH + 1);

  logic [WID_W-1:0] width_q, width_d, cfg_sat;
  logic             rel_q;
  logic             load_w;

  assign cfg_sat = (cfg_width < WID_W'(KERNEL_WIDTH) || cfg_width > WID_W'(IMAGE_WIDTH))
                 ? WID_W'(IMAGE_WIDTH) : cfg_width;
  // Reload on the first cycle out of reset, on clear, and at each frame start.
  assign load_w  = rel_q | bus.clear | (accept && col_q == '0 && row_q == '0);
  assign width_d = load_w ? cfg_sat : width_q;
  assign last_col = (WID_W'(col_q) == width_q - WID_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q <= WID_W'(IMAGE_WIDTH);
      rel_q   <= 1'b1;
    end else begin
      width_q <= width_d;
      rel_q   <= 1'b0;
    end
  end
`else
  assign last_col = (col_q == COL_W'(IMAGE_WIDTH - 1));
`endif

  // Every line is written once per accept, so the column counter is the shared pointer.
  for (genvar j = 0; j < NLINES; j++) begin : g_line
    if (j == 0) begin : g_head
      assign wd[j] = bus.in_data;
    end else begin : g_chain
      assign wd[j] = rd[j-1];
    end

    line_buffer_line #(
      .DATA_W (DATA_W),
      .DEPTH  (IMAGE_WIDTH)
    ) u_line (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (accept),
      .ptr_i   (col_q),
      .wdata_i (wd[j]),
      .rdata_o (rd[j])
    );
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    taps_d = taps_q;
    vld_d  = 1'b0;
    win_d  = 1'b0;
    fd_d   = 1'b0;
    if (bus.clear) begin
      col_d  = '0;
      row_d  = '0;
      ocol_d = '0;
      orow_d = '0;
    end else if (bus.in_valid) begin
      taps_d[TAP_CUR] = bus.in_data;
      for (int k = TAP_FIRST_LINE; k < KERNEL_WIDTH; k++)
        taps_d[k] = rd[k-TAP_FIRST_LINE];
      ocol_d = col_q;
      orow_d = row_q;
      vld_d  = (row_q >= ROW_W'(KERNEL_WIDTH - 1));
      win_d  = vld_d && (col_q >= COL_W'(KERNEL_WIDTH - 1));
      fd_d   = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      taps_q <= '0;
      vld_q  <= 1'b0;
      win_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      taps_q <= taps_d;
      vld_q  <= vld_d;
      win_q  <= win_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.out_valid     = vld_q;
  assign bus.out_win_valid = win_q;
  assign bus.out_taps      = taps_q;
  assign bus.out_col       = ocol_q;
  assign bus.out_row       = orow_q;
  assign bus.frame_done    = fd_q;

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer at W=8, H=6, K=3: ramp checkpoints, gaps, clear, random, reset.
module tb_line_buffer;
  import line_buffer_pkg::*;

  localparam int DW = 17;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int K  = 3;
  localparam int CW = clog2(IW);
  localparam int RW = clog2(IH);

  typedef logic [K-1:0][DW-1:0] taps_t;
  typedef struct {
    int pix;
    bit v, w, fd;
    int row, col;
    int t0, t1, t2;
  } chk_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

`ifdef LINE_BUFFER_CFG_WIDTH_EN
  logic [clog2(IW+1)-1:0] cfg_width;
`endif

  line_buffer_if #(.DATA_W(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .KERNEL_WIDTH(K)) bus ();

  line_buffer #(.DATA_W(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .KERNEL_WIDTH(K)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef LINE_BUFFER_CFG_WIDTH_EN
    .cfg_width (cfg_width),
`endif
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: per column, the pixels written there, newest first.
  logic [DW-1:0] hist [IW][K-1];
  int    m_col, m_row, m_w;
  bit    m_rel;
  taps_t e_taps;
  int    e_col, e_row;
  bit    e_v, e_w, e_fd;
  chk_t  tbl[$];

`ifdef LINE_BUFFER_CFG_WIDTH_EN
  function automatic int sat_w(input int c);
    return (c < K || c > IW) ? IW : c;
  endfunction
`endif

  task automatic model_reset();
    foreach (hist[c, k]) hist[c][k] = '0;
    m_col = 0; m_row = 0; m_w = IW; m_rel = 1'b1;
    e_taps = '0; e_col = 0; e_row = 0; e_v = 0; e_w = 0; e_fd = 0;
  endtask

  task automatic model_step(input bit v, input bit c, input logic [DW-1:0] d);
`ifdef LINE_BUFFER_CFG_WIDTH_EN
    if (m_rel || c || (v && m_col == 0 && m_row == 0)) m_w = sat_w(int'(cfg_width));
`endif
    m_rel = 1'b0;
    if (c) begin
      m_col = 0; m_row = 0; e_col = 0; e_row = 0;
      e_v = 0; e_w = 0; e_fd = 0;
    end else if (v) begin
      e_taps[0] = d;
      for (int k = 1; k < K; k++) e_taps[k] = hist[m_col][k-1];
      e_col = m_col; e_row = m_row;
      e_v  = (m_row >= K - 1);
      e_w  = e_v && (m_col >= K - 1);
      e_fd = (m_col == m_w - 1) && (m_row == IH - 1);
      for (int k = K - 2; k > 0; k--) hist[m_col][k] = hist[m_col][k-1];
      hist[m_col][0] = d;
      if (m_col == m_w - 1) begin
        m_col = 0;
        m_row = (m_row == IH - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else begin
      e_v = 0; e_w = 0; e_fd = 0;
    end
  endtask

  task automatic check(input string name);
    tests++;
    if (bus.out_valid !== e_v || bus.out_win_valid !== e_w || bus.frame_done !== e_fd ||
        bus.out_row !== RW'(e_row) || bus.out_col !== CW'(e_col) || bus.out_taps !== e_taps) begin
      fails++;
      $display("FAIL %s: got v=%0b w=%0b fd=%0b row=%0d col=%0d taps=%h, expected v=%0b w=%0b fd=%0b row=%0d col=%0d taps=%h",
               name, bus.out_valid, bus.out_win_valid, bus.frame_done, bus.out_row, bus.out_col,
               bus.out_taps, e_v, e_w, e_fd, e_row, e_col, e_taps);
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic expect_taps(input string name, input int t0, input int t1, input int t2);
    taps_t t;
    t[0] = DW'(t0); t[1] = DW'(t1); t[2] = DW'(t2);
    tests++;
    if (bus.out_taps !== t) begin
      fails++;
      $display("FAIL %s: got taps %h, expected %h", name, bus.out_taps, t);
    end
  endtask

  task automatic step(input bit v, input bit c, input int d, input string name);
    bus.in_valid = v;
    bus.clear    = c;
    bus.in_data  = DW'(d);
    @(posedge clk);
    model_step(v, c, DW'(d));
    #1;
    check(name);
  endtask

  task automatic check_tbl(input int p);
    foreach (tbl[i]) begin
      if (tbl[i].pix == p) begin
        expect_eq($sformatf("pix%0d_valid", p), int'(bus.out_valid), int'(tbl[i].v));
        expect_eq($sformatf("pix%0d_win", p), int'(bus.out_win_valid), int'(tbl[i].w));
        expect_eq($sformatf("pix%0d_fd", p), int'(bus.frame_done), int'(tbl[i].fd));
        expect_eq($sformatf("pix%0d_row", p), int'(bus.out_row), tbl[i].row);
        expect_eq($sformatf("pix%0d_col", p), int'(bus.out_col), tbl[i].col);
        expect_taps($sformatf("pix%0d_taps", p), tbl[i].t0, tbl[i].t1, tbl[i].t2);
      end
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    bus.clear    = 1'b0;
    bus.in_data  = DW'(5);
    model_reset();
    #1;
    check("reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.in_data  = '0;
`ifdef LINE_BUFFER_CFG_WIDTH_EN
    cfg_width = IW;
`endif
    //                 pix v w fd row col t0  t1  t2
    tbl.push_back('{15, 0, 0, 0, 1, 7, 15,  7,  0});
    tbl.push_back('{16, 1, 0, 0, 2, 0, 16,  8,  0});
    tbl.push_back('{17, 1, 0, 0, 2, 1, 17,  9,  1});
    tbl.push_back('{18, 1, 1, 0, 2, 2, 18, 10,  2});
    tbl.push_back('{47, 1, 1, 1, 5, 7, 47, 39, 31});
    tbl.push_back('{48, 0, 0, 0, 0, 0, 48, 40, 32});
    tbl.push_back('{64, 1, 0, 0, 2, 0, 64, 56, 48});

    #2;
    do_reset();

    for (int p = 0; p <= 64; p++) begin
      step(1, 0, p, "ramp");
      check_tbl(p);
    end

    do_reset();
    begin
      int p;
      int guard;
      p = 0;
      guard = 0;
      while (p <= 64 && guard < 2000) begin
        if ($urandom % 2 == 0) begin
          step(1, 0, p, "gap_accept");
          check_tbl(p);
          p++;
        end else begin
          step(0, 0, int'($urandom), "gap_hold");
        end
        guard++;
      end
      expect_eq("gap_ramp_complete", p, 65);
    end

    do_reset();
    for (int p = 0; p < 20; p++) step(1, 0, p, "pre_clear");
    step(1, 1, 20, "clear_drop");
    expect_eq("clear_valid", int'(bus.out_valid), 0);
    expect_taps("clear_taps_hold", 19, 11, 3);
    begin
      int nv;
      nv = 0;
      for (int p = 21; p <= 37; p++) begin
        step(1, 0, p, "post_clear");
        if (p == 21) begin
          expect_eq("post_clear_row", int'(bus.out_row), 0);
          expect_eq("post_clear_col", int'(bus.out_col), 0);
          expect_taps("post_clear_taps", 21, 16, 8);
        end
        if (p <= 36) nv += int'(bus.out_valid);
      end
      expect_eq("post_clear_quiet", nv, 0);
      expect_eq("post_clear_resume", int'(bus.out_valid), 1);
      expect_taps("post_clear_resume_taps", 37, 29, 21);
    end

    do_reset();
    repeat (400) step($urandom % 2 == 0, $urandom % 50 == 0, int'($urandom), "random");
    do_reset();
    repeat (400) step($urandom % 4 != 0, $urandom % 80 == 0, int'($urandom), "random2");

`ifdef LINE_BUFFER_CFG_WIDTH_EN
    cfg_width = 5;
    step(0, 1, 0, "cfg5_clear");
    for (int p = 0; p <= 10; p++) step(1, 0, p, "cfg5_ramp");
    expect_eq("cfg5_valid", int'(bus.out_valid), 1);
    expect_eq("cfg5_row", int'(bus.out_row), 2);
    expect_taps("cfg5_taps", 10, 5, 0);
    cfg_width = 2;
    step(0, 1, 0, "cfg2_clear");
    for (int p = 0; p <= 16; p++) step(1, 0, p, "cfg2_ramp");
    expect_eq("cfg2_valid", int'(bus.out_valid), 1);
    expect_taps("cfg2_taps", 16, 8, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
- Parametrised, valid-gated successor to the fixed-depth bit-sliced delay used in the conv datapath.
- Holds KERNEL_WIDTH-1 full image lines of signed pixels and presents one vertical column of KERNEL_WIDTH taps per accepted pixel.
- Tracks row and column position, and flags when a full KxK window is available downstream.
- Sits between the pixel source and the conv window/MAC stage.

Parameters:
- DATA_W, 17, signed pixel width.
- IMAGE_WIDTH, 28, pixels per line (maximum line length when the optional feature is enabled).
- IMAGE_HEIGHT, 28, lines per frame.
- KERNEL_WIDTH, 5, taps per column; the block stores KERNEL_WIDTH-1 lines.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart of the frame position.
- in_valid  in  1  in_data accepted this cycle.
- in_data  in  DATA_W  signed pixel.
- out_valid  out  1  out_taps valid (row >= KERNEL_WIDTH-1).
- out_win_valid  out  1  out_valid and col >= KERNEL_WIDTH-1; a full window is available.
- out_taps  out  KERNEL_WIDTH*DATA_W  tap k at [k*DATA_W +: DATA_W] is the pixel k lines older; tap 0 is the current pixel.
- out_col  out  clog2(IMAGE_WIDTH)  column of tap 0.
- out_row  out  clog2(IMAGE_HEIGHT)  row of tap 0.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Storage: KERNEL_WIDTH-1 circular lines of IMAGE_WIDTH entries, sharing a write pointer ptr (0..W-1, where W is the active width).
- Accept (in_valid=1, clear=0):
  - line0[ptr] <= in_data.
  - line j[ptr] <= old line j-1[ptr].
  - ptr advances and wraps W-1 -> 0.
- Read-before-write on each line: tap k = old line k-1[ptr], sampled in the same cycle.
- Latency: all outputs are registered, 1 cycle after the accept.
- Counters: col increments per accept and wraps W-1 -> 0, incrementing row. Row wraps IMAGE_HEIGHT-1 -> 0 and asserts frame_done for 1 cycle. Storage is not cleared between frames; out_valid gating hides stale data.
- out_valid = registered (accepted and row >= KERNEL_WIDTH-1).
- out_win_valid = registered (out_valid condition and col >= KERNEL_WIDTH-1).
- No accept in a cycle:
  - out_valid, out_win_valid and frame_done are 0 next cycle.
  - out_taps, out_col and out_row hold.
  - Storage and counters are unchanged.
- Back-pressure: none; the source owns pacing through in_valid.
- reset_n low, asynchronous:
  - All outputs, ptr, col and row go to 0 immediately.
  - Storage clears to 0.
  - Mid-stream reset discards the frame.
- clear:
  - Next cycle: ptr, col and row are 0; out_valid, out_win_valid and frame_done are 0.
  - out_taps holds; storage is kept.
  - clear has priority over in_valid in the same cycle; that sample is dropped.
- Arithmetic: data is never modified, only moved; sign is preserved.

Optional Feature:
- Macro: LINE_BUFFER_CFG_WIDTH_EN.
- Defined:
  - Adds port cfg_width, in, clog2(IMAGE_WIDTH+1) bits.
  - Active width W is latched from cfg_width on reset release, on clear, and on the accept that starts a new frame.
  - Values < KERNEL_WIDTH or > IMAGE_WIDTH latch as IMAGE_WIDTH.
  - ptr and col wrap at W-1.
- Undefined: no port; W = IMAGE_WIDTH constant.

Decomposition:
- Package line_buffer_pkg holds:
  - the clog2 function;
  - the tap-index constants;
  - the default DATA_W, IMAGE_WIDTH, IMAGE_HEIGHT and KERNEL_WIDTH shared with the conv window and MAC blocks.
- Sub-module line_buffer_line: one circular line with a single read-before-write port and external pointer, instantiated KERNEL_WIDTH-1 times via generate.
- Counters, valid logic and frame_done stay in the top.

Test Plan (bench params W=8, H=6, K=3):
- Reset: hold reset_n=0, drive in_valid=1 -> all outputs 0; after release, first out_valid no earlier than the 17th accept.
- Stream a ramp of pixels 0..47 back-to-back:
  - First out_valid follows pixel 16, with taps {16,8,0}, row=2, col=0.
  - First out_win_valid follows pixel 18, with taps {18,10,2}.
- Random in_valid gaps (~50% duty) with the same ramp -> identical tap/row/col sequence; out_valid only in cycles after accepts; outputs hold during gaps.
- Frame wrap: after pixel 47 -> frame_done = 1 for one cycle. Pixel 48 -> row=0, col=0, out_valid=0; out_valid resumes at the 17th accept of the new frame.
- clear with in_valid=1 on pixel 20 -> pixel 20 dropped; next accept reports row 0, col 0; no out_valid for the next 16 accepts.
- With LINE_BUFFER_CFG_WIDTH_EN, cfg_width=5, clear then ramp -> first out_valid taps {10,5,0}. With cfg_width=2 -> width 8 behaviour as above.
